ex_alu_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline.
- Consumes the operands, PC/immediate and the 4-bit ALU control code produced by the ALU control decoder. Computes the ALU result or branch condition, then registers everything into the EX/MEM pipeline register.
- Resolves branches and issues a one-cycle redirect to fetch.
- Kills the single wrong-path instruction that arrives behind a taken branch.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/alu_core.sv | 53 +++++
 rtl/ex_alu_stage.sv | 116 +++++++++++
 tb/tb_ex_alu_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 datapath constants and ALU control codes
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_BGT  = 4'b1110;

    function automatic logic is_branch(input logic [3:0] ctl);
        return (ctl == ALU_BEQ) || (ctl == ALU_BNE) || (ctl == ALU_BLT) ||
               (ctl == ALU_BGE) || (ctl == ALU_BGT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational RV32 ALU and branch comparator
module alu_core #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            cond
);
    import rv32_pkg::*;

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = op_a == op_b;

    always_comb begin
        result = '0;
        cond   = 1'b0;
        case (alu_ctl)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $signed(op_a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_BEQ:  cond = eq;
            ALU_BNE:  cond = ~eq;
            ALU_BLT:  cond = lt_s;
            ALU_BGE:  cond = ~lt_s;
            ALU_BGT:  cond = ~lt_s & ~eq;
            default: begin
                result = '0;
                cond   = 1'b0;
            end
        endcase
        // Branches report their condition as a 0/1 result word.
        if (is_branch(alu_ctl)) begin
            result = {{(XLEN-1){1'b0}}, cond};
        end
    end

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - RV32 execute stage with EX/MEM register, branch redirect and shadow kill
module ex_alu_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [RD_W-1:0] rd_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [RD_W-1:0] rd_out,
    output logic            reg_write_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic [XLEN-1:0] store_data_out,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    import rv32_pkg::is_branch;

    logic [XLEN-1:0] result_d;
    logic            cond_d;
    logic            live_d;
    logic            taken_d;
    logic            ctl_en_d;

    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [RD_W-1:0] rd_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic [XLEN-1:0] store_data_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            kill_pending_q;

    alu_core #(.XLEN(XLEN)) u_alu (
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (result_d),
        .cond    (cond_d)
    );

    // The slot right behind a taken branch is the wrong path and becomes a bubble.
    assign live_d   = in_valid & ~kill_pending_q;
    assign taken_d  = live_d & is_branch(alu_ctl) & cond_d;
    assign ctl_en_d = live_d & ~is_branch(alu_ctl);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= 1'b0;
            result_q         <= '0;
            zero_q           <= 1'b0;
            rd_q             <= '0;
            reg_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            store_data_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            kill_pending_q   <= 1'b0;
        end else if (flush) begin
            valid_q          <= 1'b0;
            zero_q           <= 1'b0;
            reg_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            kill_pending_q   <= 1'b0;
        end else if (stall) begin
            redirect_valid_q <= 1'b0;
        end else begin
            valid_q          <= live_d;
            result_q         <= result_d;
            zero_q           <= (result_d == '0);
            rd_q             <= rd_in;
            reg_write_q      <= reg_write_in & ctl_en_d;
            mem_read_q       <= mem_read_in & ctl_en_d;
            mem_write_q      <= mem_write_in & ctl_en_d;
            store_data_q     <= store_data_in;
            redirect_valid_q <= taken_d;
            kill_pending_q   <= taken_d;
            if (taken_d) begin
                redirect_pc_q <= pc + imm;
            end
        end
    end

    assign out_valid      = valid_q;
    assign alu_result     = result_q;
    assign zero           = zero_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = reg_write_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign store_data_out = store_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - directed vector bench for ex_alu_stage
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_ctl;
    logic [31:0] op_a, op_b, pc, imm, store_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_read_in, mem_write_in, stall, flush;
    logic        out_valid, zero, reg_write_out, mem_read_out, mem_write_out, redirect_valid;
    logic [31:0] alu_result, store_data_out, redirect_pc;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_alu_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .alu_ctl        (alu_ctl),
        .op_a           (op_a),
        .op_b           (op_b),
        .pc             (pc),
        .imm            (imm),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .store_data_in  (store_data_in),
        .stall          (stall),
        .flush          (flush),
        .out_valid      (out_valid),
        .alu_result     (alu_result),
        .zero           (zero),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .store_data_out (store_data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
        in_valid = v;
        alu_ctl  = ctl;
        op_a     = a;
        op_b     = b;
        pc       = p;
        imm      = i;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        rd_in = 5'd3; reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
        store_data_in = 32'hCAFE_0001;

        vecs[0]  = '{4'b1000, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[1]  = '{4'b0000, 32'd5,         32'd7,         32'h0000_000C};
        vecs[2]  = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
        vecs[3]  = '{4'b1101, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[4]  = '{4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[5]  = '{4'b0001, 32'd1,         32'h0000_0025, 32'h0000_0020};
        vecs[6]  = '{4'b0011, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
        vecs[7]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001};
        vecs[8]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[9]  = '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        vecs[10] = '{4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[11] = '{4'b1111, 32'd3,         32'd3,         32'h0000_0000};

        step();
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset alu_result", alu_result, 32'h0);
        chk("reset zero", {31'b0, zero}, 32'h0);
        chk("reset reg_write", {31'b0, reg_write_out}, 32'h0);
        chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset store_data", store_data_out, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            drive(1'b1, vecs[k].ctl, vecs[k].a, vecs[k].b, 32'h0, 32'h0);
            step();
            chk($sformatf("vec%0d result", k), alu_result, vecs[k].res);
            chk($sformatf("vec%0d zero", k), {31'b0, zero}, {31'b0, vecs[k].res == 32'h0});
            chk($sformatf("vec%0d out_valid", k), {31'b0, out_valid}, 32'h1);
            chk($sformatf("vec%0d reg_write", k), {31'b0, reg_write_out}, 32'h1);
        end
        chk("store_data passthrough", store_data_out, 32'hCAFE_0001);
        chk("rd passthrough", {27'b0, rd_out}, 32'h3);

        // Taken blt redirects, kills the next slot, then traffic resumes.
        drive(1'b1, 4'b1011, 32'hFFFF_FFFF, 32'd2, 32'h100, 32'h20);
        step();
        chk("blt redirect_valid", {31'b0, redirect_valid}, 32'h1);
        chk("blt redirect_pc", redirect_pc, 32'h120);
        chk("blt result", alu_result, 32'h1);
        chk("blt reg_write forced", {31'b0, reg_write_out}, 32'h0);
        drive(1'b1, 4'b0000, 32'd1, 32'd2, 32'h104, 32'h0);
        step();
        chk("shadow add out_valid", {31'b0, out_valid}, 32'h0);
        chk("shadow add reg_write", {31'b0, reg_write_out}, 32'h0);
        chk("redirect pulse ends", {31'b0, redirect_valid}, 32'h0);
        chk("redirect_pc holds", redirect_pc, 32'h120);
        step();
        chk("post-kill add out_valid", {31'b0, out_valid}, 32'h1);
        chk("post-kill add result", alu_result, 32'h3);

        // Taken beq, two stall cycles, then the shadow add is consumed.
        drive(1'b1, 4'b1001, 32'd7, 32'd7, 32'h200, 32'h40);
        step();
        chk("beq redirect_valid", {31'b0, redirect_valid}, 32'h1);
        chk("beq redirect_pc", redirect_pc, 32'h240);
        drive(1'b1, 4'b0000, 32'd10, 32'd20, 32'h204, 32'h0);
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            chk($sformatf("stall%0d redirect_valid", s), {31'b0, redirect_valid}, 32'h0);
            chk($sformatf("stall%0d out_valid hold", s), {31'b0, out_valid}, 32'h1);
            chk($sformatf("stall%0d result hold", s), alu_result, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("beq shadow killed", {31'b0, out_valid}, 32'h0);
        chk("beq no second redirect", {31'b0, redirect_valid}, 32'h0);
        step();
        chk("beq post add out_valid", {31'b0, out_valid}, 32'h1);
        chk("beq post add result", alu_result, 32'd30);

        // Back-to-back taken branches: the second sits in the shadow.
        drive(1'b1, 4'b1011, 32'd1, 32'd2, 32'h300, 32'h10);
        step();
        chk("b2b first redirect", {31'b0, redirect_valid}, 32'h1);
        drive(1'b1, 4'b1010, 32'd1, 32'd2, 32'h304, 32'h80);
        step();
        chk("b2b second redirect", {31'b0, redirect_valid}, 32'h0);
        chk("b2b second out_valid", {31'b0, out_valid}, 32'h0);
        chk("b2b redirect_pc", redirect_pc, 32'h310);
        drive(1'b1, 4'b0000, 32'd2, 32'd2, 32'h308, 32'h0);
        step();
        chk("b2b add out_valid", {31'b0, out_valid}, 32'h1);

        // Flush beats stall on a load.
        drive(1'b1, 4'b0000, 32'h1000, 32'd4, 32'h400, 32'h0);
        mem_read_in = 1'b1;
        flush = 1'b1; stall = 1'b1;
        step();
        chk("flush out_valid", {31'b0, out_valid}, 32'h0);
        chk("flush reg_write", {31'b0, reg_write_out}, 32'h0);
        chk("flush mem_read", {31'b0, mem_read_out}, 32'h0);
        chk("flush mem_write", {31'b0, mem_write_out}, 32'h0);
        chk("flush zero", {31'b0, zero}, 32'h0);
        flush = 1'b0; stall = 1'b0; mem_read_in = 1'b0;

        // Taken bge while reset is asserted.
        drive(1'b1, 4'b1100, 32'd3, 32'd1, 32'h500, 32'h8);
        rst = 1'b1;
        step();
        chk("rst bge redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("rst bge redirect_pc", redirect_pc, 32'h0);
        chk("rst bge out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst bge result", alu_result, 32'h0);
        rst = 1'b0;
        drive(1'b1, 4'b0000, 32'd4, 32'd5, 32'h504, 32'h0);
        step();
        chk("post-rst add out_valid", {31'b0, out_valid}, 32'h1);
        chk("post-rst add result", alu_result, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
